memory_transfer_controller: RTL and testbench

MEMORY_TRANSFER_CONTROLLER -- requirements
Module: memory_transfer_controller

---
 rtl/memory_transfer_controller_pkg.sv | 85 ++++++++
 rtl/memory_transfer_controller.sv | 105 ++++++++++
 tb/tb_memory_transfer_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_transfer_controller_pkg.sv
// rtl/memory_transfer_controller_pkg.sv - shared encodings for the memory transfer controller and its datapath bench
package memory_transfer_controller_pkg;

    typedef enum logic [1:0] {
        OP_FETCH   = 2'b00,
        OP_LOAD    = 2'b01,
        OP_STORE   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        DR_CLEAR      = 2'b00,
        DR_LOAD_BYTE  = 2'b01,
        DR_SHIFT_LOAD = 2'b10
    } dr_fun_t;

    typedef enum logic [1:0] {
        ARF_HOLD = 2'b00,
        ARF_INC  = 2'b01
    } arf_fun_t;

    typedef enum logic [1:0] {
        ADDR_PC = 2'b00,
        ADDR_SP = 2'b01,
        ADDR_AR = 2'b10
    } addr_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [2:0] REG_NONE = 3'b000;
    localparam logic [2:0] REG_PC   = 3'b100;
    localparam logic [2:0] REG_AR   = 3'b010;
    localparam logic [2:0] REG_SP   = 3'b001;

    typedef struct packed {
        logic       mem_cs;
        logic       mem_wr;
        logic       ir_write;
        logic       ir_lh;
        logic       dr_e;
        logic [1:0] dr_fun_sel;
        logic [1:0] muxc_sel;
        logic [1:0] arf_outd_sel;
        logic [2:0] arf_reg_sel;
        logic [1:0] arf_fun_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{mem_cs: 1'b1, default: '0};

    // Control word for one memory byte of a transfer; the address register
    // always post-increments so consecutive bytes walk upward in memory.
    function automatic ctrl_t xfer_ctrl(input op_t op, input logic [1:0] len, input logic [1:0] idx);
        ctrl_t c;
        c = CTRL_IDLE;
        c.mem_cs      = 1'b0;
        c.arf_fun_sel = ARF_INC;
        case (op)
            OP_FETCH: begin
                c.arf_outd_sel = ADDR_PC;
                c.ir_write     = 1'b1;
                c.ir_lh        = idx[0];
                c.arf_reg_sel  = REG_PC;
            end
            OP_LOAD: begin
                c.arf_outd_sel = ADDR_AR;
                c.dr_e         = 1'b1;
                c.dr_fun_sel   = (idx == 2'd0) ? DR_LOAD_BYTE : DR_SHIFT_LOAD;
                c.arf_reg_sel  = REG_AR;
            end
            OP_STORE: begin
                c.mem_wr       = 1'b1;
                c.arf_outd_sel = ADDR_AR;
                c.muxc_sel     = len - idx;
                c.arf_reg_sel  = REG_AR;
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/memory_transfer_controller.sv
// rtl/memory_transfer_controller.sv - byte-serial fetch/load/store sequencer with registered control outputs
module memory_transfer_controller
    import memory_transfer_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [1:0] len,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       mem_cs,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       ir_lh,
    output logic       dr_e,
    output logic [1:0] dr_fun_sel,
    output logic [1:0] muxc_sel,
    output logic [1:0] arf_outd_sel,
    output logic [2:0] arf_reg_sel,
    output logic [1:0] arf_fun_sel
);

    state_t     state;
    op_t        op_q;
    logic [1:0] len_q;
    logic [1:0] idx;
    logic [2:0] cnt;
    ctrl_t      ctrl;
    op_t        op_in;

    assign op_in = op_t'(op);

    // Controls are computed one cycle ahead and registered, so the outputs
    // never depend combinationally on start/op/len.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= OP_FETCH;
            len_q <= 2'd0;
            idx   <= 2'd0;
            cnt   <= 3'd0;
            ctrl  <= CTRL_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        idx  <= 2'd0;
                        if (op_in == OP_ILLEGAL) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state <= ST_XFER;
                            op_q  <= op_in;
                            len_q <= len;
                            cnt   <= (op_in == OP_FETCH) ? 3'd2 : ({1'b0, len} + 3'd1);
                            ctrl  <= xfer_ctrl(op_in, len, 2'd0);
                        end
                    end
                end
                ST_XFER: begin
                    if ({1'b0, idx} == cnt - 3'd1) begin
                        state <= ST_DONE;
                        ctrl  <= CTRL_IDLE;
                        done  <= 1'b1;
                    end else begin
                        idx  <= idx + 2'd1;
                        ctrl <= xfer_ctrl(op_q, len_q, idx + 2'd1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    error <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    ctrl  <= CTRL_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    error <= 1'b0;
                end
            endcase
        end
    end

    assign mem_cs       = ctrl.mem_cs;
    assign mem_wr       = ctrl.mem_wr;
    assign ir_write     = ctrl.ir_write;
    assign ir_lh        = ctrl.ir_lh;
    assign dr_e         = ctrl.dr_e;
    assign dr_fun_sel   = ctrl.dr_fun_sel;
    assign muxc_sel     = ctrl.muxc_sel;
    assign arf_outd_sel = ctrl.arf_outd_sel;
    assign arf_reg_sel  = ctrl.arf_reg_sel;
    assign arf_fun_sel  = ctrl.arf_fun_sel;

endmodule

// File: tb/tb_memory_transfer_controller.sv
// tb/tb_memory_transfer_controller.sv - directed bench driving a small datapath model from the controller outputs
module tb_memory_transfer_controller;
    import memory_transfer_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [1:0] len;
    logic       busy, done, error, mem_cs, mem_wr, ir_write, ir_lh, dr_e;
    logic [1:0] dr_fun_sel, muxc_sel, arf_outd_sel, arf_fun_sel;
    logic [2:0] arf_reg_sel;

    memory_transfer_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .len(len),
        .busy(busy), .done(done), .error(error), .mem_cs(mem_cs), .mem_wr(mem_wr),
        .ir_write(ir_write), .ir_lh(ir_lh), .dr_e(dr_e), .dr_fun_sel(dr_fun_sel),
        .muxc_sel(muxc_sel), .arf_outd_sel(arf_outd_sel), .arf_reg_sel(arf_reg_sel),
        .arf_fun_sel(arf_fun_sel)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:255];
    logic [15:0] pc, sp, ar, ir;
    logic [31:0] dr, alu;
    logic        cs_log  [0:15];
    logic        lh_log  [0:15];
    logic [1:0]  mux_log [0:15];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Datapath effect of the controls present during the cycle that ends at the next rising edge.
    task automatic model_apply();
        logic [15:0] a;
        logic [7:0]  rd;
        if (!mem_cs) begin
            case (arf_outd_sel)
                2'b00:   a = pc;
                2'b01:   a = sp;
                default: a = ar;
            endcase
            if (mem_wr) begin
                mem[a[7:0]] = alu[{muxc_sel, 3'b000} +: 8];
            end else begin
                rd = mem[a[7:0]];
                if (ir_write) begin
                    if (ir_lh) ir[15:8] = rd;
                    else       ir[7:0]  = rd;
                end
                if (dr_e) begin
                    case (dr_fun_sel)
                        2'b00:   dr = 32'd0;
                        2'b01:   dr = {24'd0, rd};
                        2'b10:   dr = {dr[23:0], rd};
                        default: dr = dr;
                    endcase
                end
            end
        end
        if (arf_fun_sel == 2'b01) begin
            if (arf_reg_sel[2]) pc = pc + 16'd1;
            if (arf_reg_sel[1]) ar = ar + 16'd1;
            if (arf_reg_sel[0]) sp = sp + 16'd1;
        end
    endtask

    task automatic step();
        model_apply();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int max, input bit hold, input bit wiggle, output int cyc, output bit err);
        cyc = -1;
        err = 1'b0;
        for (int n = 1; n <= max; n++) begin
            step();
            cs_log[n]  = mem_cs;
            lh_log[n]  = ir_lh;
            mux_log[n] = muxc_sel;
            if (!hold) start = 1'b0;
            if (wiggle && n == 1) begin start = 1'b1; op = 2'b01; len = 2'b11; end
            if (wiggle && n == 2) start = 1'b0;
            if (done) begin
                cyc = n;
                err = error;
                break;
            end
        end
    endtask

    initial begin
        int          cyc;
        bit          err;
        bit          seen;
        logic [63:0] saved;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; len = 2'b00;
        pc = 16'd0; sp = 16'd0; ar = 16'd0; ir = 16'd0; dr = 32'd0; alu = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin cs_log[i] = 1'b1; lh_log[i] = 1'b0; mux_log[i] = 2'b00; end
        @(negedge clk);
        @(negedge clk);
        check("reset_status", {29'd0, busy, done, error}, 32'h0);
        check("reset_ctrl", {16'd0, mem_cs, mem_wr, ir_write, ir_lh, dr_e, dr_fun_sel, muxc_sel,
                             arf_outd_sel, arf_reg_sel, arf_fun_sel}, 32'h0000_8000);
        rst_n = 1'b1;
        step();
        check("idle_busy", {31'd0, busy}, 32'h0);

        // fetch from PC=0x0010
        pc = 16'h0010; mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
        start = 1'b1; op = 2'b00; len = 2'b11;
        run(10, 1'b0, 1'b0, cyc, err);
        check("fetch_cycles", cyc, 3);
        check("fetch_error", {31'd0, err}, 32'h0);
        check("fetch_lh_seq", {30'd0, lh_log[1], lh_log[2]}, 32'h1);
        check("fetch_ir", {16'd0, ir}, 32'h1234);
        check("fetch_pc", {16'd0, pc}, 32'h0012);
        step();
        check("fetch_after_busy", {30'd0, busy, done}, 32'h0);

        // load four bytes from AR=0x0020
        ar = 16'h0020; dr = 32'd0;
        mem[8'h20] = 8'hDE; mem[8'h21] = 8'hAD; mem[8'h22] = 8'hBE; mem[8'h23] = 8'hEF;
        start = 1'b1; op = 2'b01; len = 2'b11;
        run(10, 1'b0, 1'b0, cyc, err);
        check("load_cycles", cyc, 5);
        check("load_dr", dr, 32'hDEAD_BEEF);
        check("load_ar", {16'd0, ar}, 32'h0024);
        step();

        // store two bytes to AR=0x0040
        alu = 32'h0000_ABCD; ar = 16'h0040;
        start = 1'b1; op = 2'b10; len = 2'b01;
        run(10, 1'b0, 1'b0, cyc, err);
        check("store_cycles", cyc, 3);
        check("store_mux_seq", {28'd0, mux_log[1], mux_log[2]}, 32'h4);
        check("store_mem", {16'd0, mem[8'h40], mem[8'h41]}, 32'hABCD);
        check("store_ar", {16'd0, ar}, 32'h0042);
        step();

        // illegal op: immediate done+error, no datapath activity
        saved = {pc, ar, ir, dr[15:0]};
        start = 1'b1; op = 2'b11; len = 2'b00;
        run(10, 1'b0, 1'b0, cyc, err);
        check("illegal_cycles", cyc, 1);
        check("illegal_error", {31'd0, err}, 32'h1);
        check("illegal_cs", {31'd0, cs_log[1]}, 32'h1);
        check("illegal_regs_hi", saved[63:32], {pc, ar});
        check("illegal_regs_lo", saved[31:0], {ir, dr[15:0]});
        step();

        // start/op/len toggled mid-transfer must not disturb a store
        alu = 32'h0000_ABCD; ar = 16'h0050;
        start = 1'b1; op = 2'b10; len = 2'b01;
        run(10, 1'b0, 1'b1, cyc, err);
        check("ignore_cycles", cyc, 3);
        check("ignore_mux_seq", {28'd0, mux_log[1], mux_log[2]}, 32'h4);
        check("ignore_mem", {16'd0, mem[8'h50], mem[8'h51]}, 32'hABCD);
        check("ignore_ar", {16'd0, ar}, 32'h0052);
        step();
        step();
        check("ignore_idle", {31'd0, busy}, 32'h0);

        // reset asserted during byte 2 of a 4-byte load
        ar = 16'h0020; dr = 32'd0;
        start = 1'b1; op = 2'b01; len = 2'b11;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_status", {30'd0, busy, done}, 32'h0);
        check("rst_mid_ctrl", {16'd0, mem_cs, mem_wr, ir_write, ir_lh, dr_e, dr_fun_sel, muxc_sel,
                               arf_outd_sel, arf_reg_sel, arf_fun_sel}, 32'h0000_8000);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); seen = seen | done | error; end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin step(); seen = seen | done | error; end
        check("rst_no_done", {31'd0, seen}, 32'h0);

        // recovery fetch with start held high across DONE launches a second fetch
        pc = 16'h0010; ir = 16'd0; mem[8'h12] = 8'h78; mem[8'h13] = 8'h56;
        start = 1'b1; op = 2'b00;
        run(10, 1'b1, 1'b0, cyc, err);
        check("recover_cycles", cyc, 3);
        check("recover_ir", {16'd0, ir}, 32'h1234);
        step();
        check("b2b_idle_gap", {31'd0, busy}, 32'h0);
        step();
        check("b2b_relaunch", {31'd0, busy}, 32'h1);
        start = 1'b0;
        run(10, 1'b0, 1'b0, cyc, err);
        check("b2b_cycles", cyc, 2);
        check("b2b_ir", {16'd0, ir}, 32'h5678);
        check("b2b_pc", {16'd0, pc}, 32'h0014);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
